dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (cpu / dma) arbiter in front of a single-port combinational-read data memory.
// Latency: request sampled at edge N -> memory access during cycle N+1 -> ack pulse during cycle N+2.
// Backpressure: requesters hold req until their ack; cpu_stall = cpu_req & ~cpu_ack.
// Option: define DMEM_ARB_RR_EN for round-robin on simultaneous requests (default: cpu has fixed priority).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              cpu_ack,
    output logic              dma_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    // last_q tracks the most recent grant for round-robin; it resets to dma so
    // the cpu wins the first contended cycle, while the visible owner resets to 0.
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic              cpu_elig;
    logic              dma_elig;
    logic              grant_dma;

    // A port that is acking this cycle is still showing its old request, so it
    // is excluded from arbitration at this edge.
    assign cpu_elig = cpu_req & ~cpu_ack_q;
    assign dma_elig = dma_req & ~dma_ack_q;

    // Winner selection among eligible requesters.
`ifdef DMEM_ARB_RR_EN
    assign grant_dma = (cpu_elig & dma_elig) ? ~last_q : dma_elig;
`else
    assign grant_dma = ~cpu_elig;
`endif

    // Next-state logic: grant in IDLE, complete (ack + read capture) at the end of ACCESS.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_elig | dma_elig) begin
                    state_d = ACCESS;
                    owner_d = grant_dma;
                    last_d  = grant_dma;
                    we_d    = grant_dma ? dma_we    : cpu_we;
                    addr_d  = grant_dma ? dma_addr  : cpu_addr;
                    wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (owner_q) begin
                    dma_ack_d = 1'b1;
                    if (!we_q) dma_rdata_d = mem_rdata;
                end else begin
                    cpu_ack_d = 1'b1;
                    if (!we_q) cpu_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any access in flight without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Memory side is driven only during ACCESS; reset gates the write strobe
    // combinationally so an aborted access never commits.
    assign busy      = (state_q == ACCESS);
    assign mem_addr  = busy ? addr_q  : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign mem_we    = busy & we_q & ~reset;

    assign owner     = owner_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction model.
// Hosts a 64-word combinational-read memory behind the arbiter.
// Requesters obey the hold-until-ack protocol; random withdrawal happens only before grant.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic          cpu_ack, dma_ack, cpu_stall, mem_we, busy, owner;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int nvec = 0;
    int nerr = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .cpu_ack(cpu_ack), .dma_ack(dma_ack), .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata),
        .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model seen by the DUT; cleared while mem_clr is high.
    logic [DW-1:0] tb_mem [64];
    logic          mem_clr;
    assign mem_rdata = tb_mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= '0;
        end else if (mem_we) begin
            tb_mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    // Reference model: one outstanding transaction, its owner, and per-port results.
    logic          m_busy, m_owner, m_last, m_cack, m_dack, m_lwe;
    logic [AW-1:0] m_laddr;
    logic [DW-1:0] m_lwdata, m_crd, m_drd;
    logic [DW-1:0] m_mem [64];

    logic [133:0] obs, expv;
    assign obs  = {busy, owner, cpu_ack, dma_ack, cpu_stall, mem_we, mem_addr, mem_wdata, cpu_rdata, dma_rdata};
    assign expv = {m_busy, m_owner, m_cack, m_dack, cpu_req & ~m_cack, m_busy & m_lwe & ~reset,
                   m_busy ? m_laddr : 32'h0, m_busy ? m_lwdata : 32'h0, m_crd, m_drd};

    // Advance one clock edge and apply the arbitration rules to the model.
    task automatic step();
        logic ce, de, win_dma;
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_owner = 0; m_last = 1; m_cack = 0; m_dack = 0;
            m_lwe = 0; m_laddr = '0; m_lwdata = '0; m_crd = '0; m_drd = '0;
        end else if (m_busy) begin
            if (m_lwe) m_mem[m_laddr[7:2]] = m_lwdata;
            else if (m_owner) m_drd = m_mem[m_laddr[7:2]];
            else m_crd = m_mem[m_laddr[7:2]];
            m_cack = !m_owner;
            m_dack = m_owner;
            m_busy = 0;
        end else begin
            ce = cpu_req && !m_cack;
            de = dma_req && !m_dack;
            m_cack = 0;
            m_dack = 0;
            if (ce || de) begin
`ifdef DMEM_ARB_RR_EN
                win_dma = (ce && de) ? !m_last : de;
`else
                win_dma = !ce;
`endif
                m_busy = 1; m_owner = win_dma; m_last = win_dma;
                m_lwe    = win_dma ? dma_we    : cpu_we;
                m_laddr  = win_dma ? dma_addr  : cpu_addr;
                m_lwdata = win_dma ? dma_wdata : cpu_wdata;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        step();
        @(negedge clk);
        nvec++;
        if ({busy, owner, cpu_ack, dma_ack, mem_we, cpu_stall} !== 6'b0) begin
            nerr++; $display("FAIL reset_ctrl got %b want 000000", {busy, owner, cpu_ack, dma_ack, mem_we, cpu_stall});
        end
        nvec++;
        if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 128'h0) begin
            nerr++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata});
        end
        step();
        reset = 0;
    endtask

    task automatic test_cpu_write_read();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h5A5A5A5A;
        @(negedge clk);
        nvec++;
        if (cpu_stall !== 1'b1) begin nerr++; $display("FAIL wr_stall_c0 got %b want 1", cpu_stall); end
        step();
        @(negedge clk);
        nvec++;
        if ({busy, mem_we, cpu_stall, mem_addr, mem_wdata} !== {3'b111, 32'h10, 32'h5A5A5A5A}) begin
            nerr++; $display("FAIL wr_access_c1 got %h want %h", {busy, mem_we, cpu_stall, mem_addr, mem_wdata}, {3'b111, 32'h10, 32'h5A5A5A5A});
        end
        step();
        cpu_req = 0;
        @(negedge clk);
        nvec++;
        if ({cpu_ack, cpu_stall, busy} !== 3'b100) begin nerr++; $display("FAIL wr_ack_c2 got %b want 100", {cpu_ack, cpu_stall, busy}); end
        step();
        @(negedge clk);
        nvec++;
        if (cpu_ack !== 1'b0) begin nerr++; $display("FAIL wr_ack_pulse got %b want 0", cpu_ack); end
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        step();
        @(negedge clk);
        nvec++;
        if ({busy, mem_we, mem_addr} !== {2'b10, 32'h10}) begin nerr++; $display("FAIL rd_access got %h want %h", {busy, mem_we, mem_addr}, {2'b10, 32'h10}); end
        step();
        cpu_req = 0;
        @(negedge clk);
        nvec++;
        if ({cpu_ack, cpu_rdata, dma_rdata} !== {1'b1, 32'h5A5A5A5A, 32'h0}) begin
            nerr++; $display("FAIL rd_data got %h want %h", {cpu_ack, cpu_rdata, dma_rdata}, {1'b1, 32'h5A5A5A5A, 32'h0});
        end
        step();
    endtask

    task automatic test_simultaneous();
        reset = 1; step(); reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hA5A5A5A5;
        step();
        @(negedge clk);
        nvec++;
        if ({busy, owner, mem_we, mem_addr} !== {3'b100, 32'h10}) begin nerr++; $display("FAIL sim_c1 got %h want %h", {busy, owner, mem_we, mem_addr}, {3'b100, 32'h10}); end
        step();
        cpu_req = 0;
        @(negedge clk);
        nvec++;
        if ({cpu_ack, dma_ack, busy, cpu_rdata} !== {3'b100, 32'h5A5A5A5A}) begin nerr++; $display("FAIL sim_c2 got %h want %h", {cpu_ack, dma_ack, busy, cpu_rdata}, {3'b100, 32'h5A5A5A5A}); end
        step();
        @(negedge clk);
        nvec++;
        if ({busy, owner, mem_we, dma_ack, mem_addr, mem_wdata} !== {4'b1110, 32'h20, 32'hA5A5A5A5}) begin
            nerr++; $display("FAIL sim_c3 got %h want %h", {busy, owner, mem_we, dma_ack, mem_addr, mem_wdata}, {4'b1110, 32'h20, 32'hA5A5A5A5});
        end
        step();
        dma_req = 0;
        @(negedge clk);
        nvec++;
        if ({dma_ack, cpu_ack, busy} !== 3'b100) begin nerr++; $display("FAIL sim_c4 got %b want 100", {dma_ack, cpu_ack, busy}); end
        step();
    endtask

    task automatic test_back_to_back();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h11111111;
        step();
        step();
        cpu_addr = 32'h44; cpu_wdata = 32'h22222222;
        @(negedge clk);
        nvec++;
        if ({cpu_ack, busy} !== 2'b10) begin nerr++; $display("FAIL b2b_ack got %b want 10", {cpu_ack, busy}); end
        step();
        @(negedge clk);
        nvec++;
        if ({cpu_ack, busy, cpu_stall} !== 3'b001) begin nerr++; $display("FAIL b2b_no_dup got %b want 001", {cpu_ack, busy, cpu_stall}); end
        step();
        @(negedge clk);
        nvec++;
        if ({busy, owner, mem_addr, mem_wdata} !== {2'b10, 32'h44, 32'h22222222}) begin
            nerr++; $display("FAIL b2b_second got %h want %h", {busy, owner, mem_addr, mem_wdata}, {2'b10, 32'h44, 32'h22222222});
        end
        step();
        cpu_req = 0;
        @(negedge clk);
        nvec++;
        if (cpu_ack !== 1'b1) begin nerr++; $display("FAIL b2b_ack2 got %b want 1", cpu_ack); end
        step();
    endtask

    task automatic test_reset_abort();
        dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'hC0FFEE01;
        step(); step();
        dma_req = 0;
        step(); step();
        dma_req = 1; dma_wdata = 32'hDEADBEEF;
        step();
        reset = 1;
        @(negedge clk);
        nvec++;
        if ({busy, mem_we} !== 2'b10) begin nerr++; $display("FAIL abort_we got %b want 10", {busy, mem_we}); end
        step();
        reset = 0; dma_req = 0;
        @(negedge clk);
        nvec++;
        if ({dma_ack, busy, dma_rdata} !== 34'h0) begin nerr++; $display("FAIL abort_noack got %h want 0", {dma_ack, busy, dma_rdata}); end
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
        step(); step();
        cpu_req = 0;
        @(negedge clk);
        nvec++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 32'hC0FFEE01}) begin nerr++; $display("FAIL abort_readback got %h want %h", {cpu_ack, cpu_rdata}, {1'b1, 32'hC0FFEE01}); end
        step();
    endtask

    task automatic test_withdraw();
        dma_req = 1; dma_we = 0; dma_addr = 32'h10;
        step();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h50; cpu_wdata = 32'h33333333;
        @(negedge clk);
        nvec++;
        if ({busy, owner} !== 2'b11) begin nerr++; $display("FAIL wd_dma_access got %b want 11", {busy, owner}); end
        step();
        cpu_req = 0; dma_req = 0;
        @(negedge clk);
        nvec++;
        if ({dma_ack, dma_rdata} !== {1'b1, 32'h5A5A5A5A}) begin nerr++; $display("FAIL wd_dma_ack got %h want %h", {dma_ack, dma_rdata}, {1'b1, 32'h5A5A5A5A}); end
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++;
            if ({cpu_ack, busy} !== 2'b00) begin nerr++; $display("FAIL wd_never_granted cyc %0d got %b want 00", i, {cpu_ack, busy}); end
            step();
        end
    endtask

    task automatic test_random();
        logic [5:0] w;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            if (m_cack || !cpu_req) begin
                cpu_req = ($urandom_range(0, 2) != 0);
                cpu_we = 1'($urandom_range(0, 1));
                w = 6'($urandom_range(0, 63)); cpu_addr = {24'h0, w, 2'b00};
                cpu_wdata = $urandom;
            end else if (!(m_busy && !m_owner) && $urandom_range(0, 15) == 0) begin
                cpu_req = 0;
            end
            if (m_dack || !dma_req) begin
                dma_req = ($urandom_range(0, 2) != 0);
                dma_we = 1'($urandom_range(0, 1));
                w = 6'($urandom_range(0, 63)); dma_addr = {24'h0, w, 2'b00};
                dma_wdata = $urandom;
            end else if (!(m_busy && m_owner) && $urandom_range(0, 15) == 0) begin
                dma_req = 0;
            end
            @(negedge clk);
            nvec++;
            if (obs !== expv) begin nerr++; $display("FAIL random cyc %0d got %h want %h", i, obs, expv); end
            step();
        end
        cpu_req = 0; dma_req = 0; reset = 0;
    endtask

    initial begin
        reset = 1; mem_clr = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        m_busy = 0; m_owner = 0; m_last = 1; m_cack = 0; m_dack = 0;
        m_lwe = 0; m_laddr = '0; m_lwdata = '0; m_crd = '0; m_drd = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        #1;
        test_reset();
        mem_clr = 0;
        test_cpu_write_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_abort();
        test_withdraw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
